// File: rtl/ifq_pkg.sv
// Shared IFQ definitions: fetch FSM state encodings and instruction/PC constants.
package ifq_pkg;

    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2
    } ifq_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// IFQ storage: circular buffer of {instruction, pc+4} entries with flush and occupancy count.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    localparam int ENT_W = INST_W + ADDR_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [ENT_W-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [ENT_W-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: fetch FSM, fetch PC, stale-response drop and head presentation.
// Optional feature: define IFQ_BYPASS_EN to forward a response straight to the head when empty.
module ifq
    import ifq_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jmp_branch_valid,
    input  logic [ADDR_W-1:0] jmp_branch_address,
    output logic              icache_rd_en,
    output logic [ADDR_W-1:0] icache_addr,
    input  logic [INST_W-1:0] icache_rdata,
    input  logic              icache_valid,
    output logic              ifq_empty,
    output logic [INST_W-1:0] ifq_inst,
    output logic [ADDR_W-1:0] ifq_pc_plus4,
    input  logic              dispatch_rd_en
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = INST_W + ADDR_W;

    ifq_state_e        r_state;
    ifq_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_pend;
    logic              r_drop;
    logic [ADDR_W-1:0] w_req_pc4;
    logic              w_redirect;
    logic              w_resp_ok;
    logic              w_room;
    logic              w_issue;
    logic              w_fifo_pop;
    logic              w_pop_ok;
    logic              w_push;
    logic              w_bypass_vis;
    logic              w_bypass_take;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [CNT_W-1:0]  w_count;
    logic [ENT_W-1:0]  w_wdata;
    logic [ENT_W-1:0]  w_rdata;

    // A redirect seen while rst_n is low must not raise a fetch request.
    assign w_redirect = jmp_branch_valid & rst_n;
    assign w_req_pc4  = r_req_pc + ADDR_W'(PC_STEP);
    assign w_resp_ok  = icache_valid & r_pend & ~r_drop & ~w_redirect;
    assign w_room     = ~w_fifo_full &
                        (({1'b0, w_count} + (CNT_W+1)'(r_pend)) < (CNT_W+1)'(DEPTH));
    assign w_fifo_pop = dispatch_rd_en & ~w_redirect;
    assign w_pop_ok   = w_fifo_pop & ~w_fifo_empty;
    assign w_wdata    = {icache_rdata, w_req_pc4};

`ifdef IFQ_BYPASS_EN
    assign w_bypass_vis = w_fifo_empty & w_resp_ok;
`else
    assign w_bypass_vis = 1'b0;
`endif
    assign w_bypass_take = w_bypass_vis & dispatch_rd_en;
    assign w_push        = w_resp_ok & ~w_bypass_take;

    ifq_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_fifo_pop),
        .i_flush (w_redirect),
        .o_rdata (w_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    always_comb begin
        ifq_empty    = 1'b1;
        ifq_inst     = '0;
        ifq_pc_plus4 = '0;
        if (!w_fifo_empty) begin
            ifq_empty                = 1'b0;
            {ifq_inst, ifq_pc_plus4} = w_rdata;
        end else if (w_bypass_vis) begin
            ifq_empty    = 1'b0;
            ifq_inst     = icache_rdata;
            ifq_pc_plus4 = w_req_pc4;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        icache_rd_en = 1'b0;
        icache_addr  = r_fetch_pc;
        w_issue      = 1'b0;
        if (w_redirect) begin
            icache_rd_en = 1'b1;
            icache_addr  = jmp_branch_address;
            w_state_nxt  = ST_FETCH;
        end else begin
            case (r_state)
                ST_BOOT:  w_state_nxt = ST_FETCH;
                ST_FETCH: begin
                    if (w_room) begin
                        icache_rd_en = 1'b1;
                        w_issue      = 1'b1;
                    end else begin
                        w_state_nxt = ST_STALL;
                    end
                end
                ST_STALL: if (w_pop_ok) w_state_nxt = ST_FETCH;
                default:  w_state_nxt = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_pend     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= icache_rd_en;
            if (w_redirect) begin
                r_fetch_pc <= jmp_branch_address + ADDR_W'(PC_STEP);
                r_req_pc   <= jmp_branch_address;
                // An older response still owed after this cycle must not reach the queue.
                r_drop     <= r_pend & ~icache_valid;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
                    r_req_pc   <= r_fetch_pc;
                end
                if (icache_valid) r_drop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifq.sv
// Bench for ifq: directed vector table, hand-written corner sequences, randomized run against a queue model.
module tb_ifq;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              jmp_branch_valid;
    logic [ADDR_W-1:0] jmp_branch_address;
    logic              icache_rd_en;
    logic [ADDR_W-1:0] icache_addr;
    logic [31:0]       icache_rdata;
    logic              icache_valid;
    logic              ifq_empty;
    logic [31:0]       ifq_inst;
    logic [ADDR_W-1:0] ifq_pc_plus4;
    logic              dispatch_rd_en;

    ifq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .jmp_branch_valid   (jmp_branch_valid),
        .jmp_branch_address (jmp_branch_address),
        .icache_rd_en       (icache_rd_en),
        .icache_addr        (icache_addr),
        .icache_rdata       (icache_rdata),
        .icache_valid       (icache_valid),
        .ifq_empty          (ifq_empty),
        .ifq_inst           (ifq_inst),
        .ifq_pc_plus4       (ifq_pc_plus4),
        .dispatch_rd_en     (dispatch_rd_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h0000_ABCD;
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    // Reference model: queue contents plus the fetch rules stated in terms of boot/stall/in-flight.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_fetch_pc;
    bit          m_boot;
    bit          m_stall;
    bit          m_infl;
    logic [31:0] m_infl_addr;

    bit          s_rd;
    logic [31:0] s_addr;
    bit          s_empty;
    logic [31:0] s_inst;
    logic [31:0] s_pc4;
    int          s_cnt;

    task automatic model_reset();
        q.delete();
        m_fetch_pc  = 32'h0;
        m_boot      = 1'b1;
        m_stall     = 1'b0;
        m_infl      = 1'b0;
        m_infl_addr = 32'h0;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step(input bit jmp, input logic [31:0] tgt, input bit pop);
        int          sz;
        bit          resp_ok, byp, e_rd, e_empty, c_req;
        logic [31:0] e_addr, c_addr;
        ent_t        e_head;
        jmp_branch_valid   = jmp;
        jmp_branch_address = tgt;
        dispatch_rd_en     = pop;
        #2;
        sz      = q.size();
        resp_ok = icache_valid && m_infl && !jmp;
        byp     = BYP && (sz == 0) && resp_ok;
        e_empty = (sz == 0) && !byp;
        if (sz > 0) e_head = q[0];
        else        e_head = '{inst: icache_rdata, pc4: m_infl_addr + 32'd4};
        e_rd   = 1'b0;
        e_addr = m_fetch_pc;
        if (jmp) begin
            e_rd   = 1'b1;
            e_addr = tgt;
        end else if (!m_boot && !m_stall && (sz + int'(m_infl) < DEPTH)) begin
            e_rd = 1'b1;
        end
        s_rd = icache_rd_en; s_addr = icache_addr; s_empty = ifq_empty;
        s_inst = ifq_inst; s_pc4 = ifq_pc_plus4; s_cnt = int'(dut.u_fifo.o_count);
        chk("rd_en", 64'(icache_rd_en), 64'(e_rd));
        if (e_rd) chk("icache_addr", 64'(icache_addr), 64'(e_addr));
        chk("empty", 64'(ifq_empty), 64'(e_empty));
        if (!e_empty) begin
            chk("inst", 64'(ifq_inst), 64'(e_head.inst));
            chk("pc_plus4", 64'(ifq_pc_plus4), 64'(e_head.pc4));
        end
        chk("occupancy", 64'(s_cnt), 64'(sz));
        c_req  = icache_rd_en;
        c_addr = icache_addr;
        if (jmp) begin
            q.delete();
            m_fetch_pc = tgt + 32'd4;
            m_stall    = 1'b0;
        end else begin
            if (!(byp && pop)) begin
                if (pop && sz > 0) void'(q.pop_front());
                if (resp_ok) q.push_back('{inst: icache_rdata, pc4: m_infl_addr + 32'd4});
            end
            if (m_stall) begin
                if (pop && sz > 0) m_stall = 1'b0;
            end else if (!m_boot) begin
                if (e_rd) m_fetch_pc = m_fetch_pc + 32'd4;
                else      m_stall = 1'b1;
            end
        end
        m_boot      = 1'b0;
        m_infl      = e_rd;
        m_infl_addr = e_addr;
        @(posedge clk); #1;
        icache_valid = c_req;
        icache_rdata = mem(c_addr);
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        jmp_branch_valid = 1'b0;
        dispatch_rd_en   = 1'b0;
        #2;
        chk("rst_rd_en", 64'(icache_rd_en), 64'd0);
        chk("rst_empty", 64'(ifq_empty), 64'd1);
        chk("rst_inst", 64'(ifq_inst), 64'd0);
        chk("rst_pc4", 64'(ifq_pc_plus4), 64'd0);
        chk("rst_count", 64'(dut.u_fifo.o_count), 64'd0);
        @(posedge clk); #1;
        icache_valid = 1'b1;
        icache_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          pop;
        bit          e_rd;
        logic [31:0] e_addr;
        bit          e_empty;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        int          e_cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int thr;
        logic [31:0] tgt;
        tbl[0]  = '{1, 0, 32'h00, 1,    32'h00, 32'h00, 0};
        tbl[1]  = '{1, 1, 32'h00, 1,    32'h00, 32'h00, 0};
        tbl[2]  = '{0, 1, 32'h04, !BYP, 32'h11, 32'h04, 0};
        tbl[3]  = '{0, 1, 32'h08, 0,    32'h11, 32'h04, 1};
        tbl[4]  = '{0, 1, 32'h0C, 0,    32'h11, 32'h04, 2};
        tbl[5]  = '{0, 0, 32'h00, 0,    32'h11, 32'h04, 3};
        tbl[6]  = '{0, 0, 32'h00, 0,    32'h11, 32'h04, 4};
        tbl[7]  = '{1, 0, 32'h00, 0,    32'h11, 32'h04, 4};
        tbl[8]  = '{0, 1, 32'h10, 0,    32'h22, 32'h08, 3};
        tbl[9]  = '{0, 0, 32'h00, 0,    32'h22, 32'h08, 3};
        tbl[10] = '{1, 0, 32'h00, 0,    32'h22, 32'h08, 4};
        tbl[11] = '{0, 1, 32'h14, 0,    32'h33, 32'h0C, 3};
        tbl[12] = '{1, 0, 32'h00, 0,    32'h33, 32'h0C, 3};
        tbl[13] = '{0, 0, 32'h00, 0,    32'h44, 32'h10, 3};
        tbl[14] = '{1, 0, 32'h00, 0,    32'h44, 32'h10, 3};
        tbl[15] = '{0, 1, 32'h18, 0,    32'h55, 32'h14, 2};

        rst_n = 1'b0;
        jmp_branch_valid = 1'b0;
        jmp_branch_address = '0;
        dispatch_rd_en = 1'b0;
        icache_valid = 1'b0;
        icache_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_rd_en", 64'(icache_rd_en), 64'd0);
        chk("rst_empty", 64'(ifq_empty), 64'd1);
        chk("rst_inst", 64'(ifq_inst), 64'd0);
        chk("rst_pc4", 64'(ifq_pc_plus4), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(1'b0, 32'h0, tbl[i].pop);
            chk($sformatf("vec%0d_rd_en", i), 64'(s_rd), 64'(tbl[i].e_rd));
            if (tbl[i].e_rd) chk($sformatf("vec%0d_addr", i), 64'(s_addr), 64'(tbl[i].e_addr));
            chk($sformatf("vec%0d_empty", i), 64'(s_empty), 64'(tbl[i].e_empty));
            if (!tbl[i].e_empty) begin
                chk($sformatf("vec%0d_inst", i), 64'(s_inst), 64'(tbl[i].e_inst));
                chk($sformatf("vec%0d_pc4", i), 64'(s_pc4), 64'(tbl[i].e_pc4));
            end
            chk($sformatf("vec%0d_count", i), 64'(s_cnt), 64'(tbl[i].e_cnt));
        end

        // Redirect while the response for 0x18 is arriving.
        step(1'b1, 32'h100, 1'b1);
        chk("redir_rd_en", 64'(s_rd), 64'd1);
        chk("redir_addr", 64'(s_addr), 64'h100);
        step(1'b0, 32'h0, 1'b0);
        chk("redir_flush_empty", 64'(s_empty), 64'(!BYP));
        chk("redir_flush_count", 64'(s_cnt), 64'd0);
        step(1'b0, 32'h0, 1'b0);
        chk("redir_head_inst", 64'(s_inst), 64'h451);
        chk("redir_head_pc4", 64'(s_pc4), 64'h104);

        // Fetch PC wrap.
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        chk("wrap_addr0", 64'(s_addr), 64'hFFFF_FFF8);
        step(1'b0, 32'h0, 1'b1);
        chk("wrap_addr1", 64'(s_addr), 64'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1);
        chk("wrap_rd_en", 64'(s_rd), 64'd1);
        chk("wrap_addr2", 64'(s_addr), 64'h0);

        // Back-to-back redirects: the last target wins.
        step(1'b1, 32'h300, 1'b0);
        step(1'b1, 32'h400, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("b2b_inst", 64'(s_inst), 64'h1111);
        chk("b2b_pc4", 64'(s_pc4), 64'h404);

`ifdef IFQ_BYPASS_EN
        step(1'b1, 32'h200, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk("byp_empty", 64'(s_empty), 64'd0);
        chk("byp_inst", 64'(s_inst), 64'hABCD);
        chk("byp_pc4", 64'(s_pc4), 64'h204);
        step(1'b0, 32'h0, 1'b0);
        chk("byp_count", 64'(s_cnt), 64'd0);
`endif

        // Reset in mid-operation with a stale response landing after release.
        step(1'b0, 32'h0, 1'b0);
        reset_mid();
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("stale_resp_count", 64'(s_cnt), 64'd0);
        chk("stale_resp_empty", 64'(s_empty), 64'd1);

        thr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) thr = int'($urandom_range(10, 90));
            tgt = {$urandom()} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ({30'd0, 2'($urandom_range(0, 3))} << 2);
            step($urandom_range(0, 24) == 0, tgt, int'($urandom_range(0, 99)) < thr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
